// File: rtl/seq_shift_unit.sv
// seq_shift_unit: sequential shifter/rotator that performs one 1-bit step per
// clock. An accepted request latches operand and opcode, runs N single-bit
// steps in SHIFT, then publishes RESULT/CARRY/ZERO/ILLEGAL on entry to FINISH,
// where DONE pulses for one cycle. Only WIDTH = 8 is supported.
module seq_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [WIDTH-1:0] AMOUNT,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ILLEGAL
);

  // Count register must hold 0..WIDTH inclusive, hence one extra bit.
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [WIDTH-1:0] AMT_SAT  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Opcodes 101..111 have no defined operation.
  function automatic logic is_illegal_op(input logic [2:0] op);
    logic ill;
    case (op)
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: ill = 1'b0;
      default:                                ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Effective step count: linear shifts saturate at WIDTH (further steps
  // would not change the result), rotates wrap modulo WIDTH, illegal is 0.
  function automatic logic [CNT_W-1:0] eff_count(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] amt);
    logic [CNT_W-1:0] cnt;
    case (op)
      OP_LSL, OP_LSR, OP_ASR: begin
        if (amt >= AMT_SAT) begin
          cnt = CNT_SAT;
        end else begin
          cnt = amt[CNT_W-1:0];
        end
      end
      OP_ROL, OP_ROR: cnt = {1'b0, amt[SH_W-1:0]};
      default:        cnt = CNT_ZERO;
    endcase
    return cnt;
  endfunction

  // One 1-bit step; returns {bit moved out, new value}.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] op,
                                             input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (op)
      OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [WIDTH-1:0] work_q,    work_d;
  logic [2:0]       op_q,      op_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             carry_q,   carry_d;
  logic             zero_q,    zero_d;
  logic             illegal_q, illegal_d;

  logic [CNT_W-1:0] start_cnt_s;
  logic [WIDTH:0]   step_s;

  // Next-state and datapath: accept in IDLE/FINISH, step in SHIFT, and
  // update the published outputs only on the edge that enters FINISH.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    work_d      = work_q;
    op_d        = op_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    start_cnt_s = eff_count(OPCODE, AMOUNT);
    step_s      = step_fn(op_q, work_q);

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (START) begin
          work_d  = DATA_IN;
          op_d    = OPCODE;
          count_d = start_cnt_s;
          if (start_cnt_s == CNT_ZERO) begin
            // Nothing to shift: publish the operand unchanged right away.
            state_d   = ST_FINISH;
            result_d  = DATA_IN;
            carry_d   = 1'b0;
            zero_d    = (DATA_IN == DATA_ZERO);
            illegal_d = is_illegal_op(OPCODE);
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // START is deliberately not looked at here.
        work_d  = step_s[WIDTH-1:0];
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d   = ST_FINISH;
          result_d  = step_s[WIDTH-1:0];
          carry_d   = step_s[WIDTH];
          zero_d    = (step_s[WIDTH-1:0] == DATA_ZERO);
          illegal_d = 1'b0;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // State and result registers with asynchronous reset to the idle/empty view.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_ZERO;
      work_q    <= DATA_ZERO;
      op_q      <= 3'b000;
      result_q  <= DATA_ZERO;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      work_q    <= work_d;
      op_q      <= op_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign RESULT  = result_q;
  assign CARRY   = carry_q;
  assign ZERO    = zero_q;
  assign ILLEGAL = illegal_q;
  assign BUSY    = (state_q == ST_SHIFT);
  assign DONE    = (state_q == ST_FINISH);

  seq_shift_unit_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .CLK    (CLK),
    .RESET  (RESET),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

endmodule

// seq_shift_unit_chk: protocol properties of the shifter's status outputs.
module seq_shift_unit_chk #(
  parameter int WIDTH = 8
) (
  input logic             CLK,
  input logic             RESET,
  input logic             BUSY,
  input logic             DONE,
  input logic [WIDTH-1:0] RESULT
);

  // BUSY and DONE come from mutually exclusive states.
  a_busy_done_excl: assert property (@(posedge CLK) disable iff (RESET)
    !(BUSY && DONE));

  // The published result never moves while an operation is in flight.
  a_result_hold: assert property (@(posedge CLK) disable iff (RESET)
    (BUSY && $past(BUSY)) |-> $stable(RESULT));

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: table-driven directed test of seq_shift_unit plus
// hand-written sequences for mid-shift START, back-to-back and mid-shift reset.
module tb_seq_shift_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] OPCODE;
  logic [7:0] DATA_IN;
  logic [7:0] AMOUNT;
  logic [7:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       BUSY;
  logic       DONE;
  logic       ILLEGAL;

  int checks = 0;
  int errors = 0;

  seq_shift_unit #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .OPCODE  (OPCODE),
    .DATA_IN (DATA_IN),
    .AMOUNT  (AMOUNT),
    .RESULT  (RESULT),
    .CARRY   (CARRY),
    .ZERO    (ZERO),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ILLEGAL (ILLEGAL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic [7:0] amt;
    logic [7:0] res;
    logic       car;
    logic       zer;
    logic       ill;
    int         n;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive a request one edge wide, then scramble inputs to prove they were latched.
  task automatic start_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
    OPCODE  = op;
    DATA_IN = d;
    AMOUNT  = a;
    START   = 1'b1;
    @(posedge CLK);
    #1;
    START   = 1'b0;
    OPCODE  = 3'b110;
    DATA_IN = ~d;
    AMOUNT  = 8'hFF;
  endtask

  // From the sample after the accepting edge, count cycles until DONE.
  task automatic wait_done(input string nm, input logic [7:0] held,
                           output int lat, output int busy_n, output int unstable);
    lat = 0;
    busy_n = 0;
    unstable = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) busy_n++;
      if (RESULT !== held) unstable++;
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({nm, "_done_seen"}, {31'd0, DONE}, 32'd1);
  endtask

  initial begin
    int lat, bn, un, dn;
    logic [7:0] held;
    string nm;

    //            op      din    amt    res    car   zer   ill   n
    tbl[0]  = '{3'b000, 8'h81, 8'd1,   8'h02, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'b010, 8'h90, 8'd3,   8'hF2, 1'b0, 1'b0, 1'b0, 3};
    tbl[2]  = '{3'b011, 8'hA5, 8'd12,  8'h5A, 1'b0, 1'b0, 1'b0, 4};
    tbl[3]  = '{3'b100, 8'h01, 8'd1,   8'h80, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{3'b001, 8'hFF, 8'd200, 8'h00, 1'b1, 1'b1, 1'b0, 8};
    tbl[5]  = '{3'b001, 8'h3C, 8'd0,   8'h3C, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{3'b111, 8'h5A, 8'd5,   8'h5A, 1'b0, 1'b0, 1'b1, 0};
    tbl[7]  = '{3'b011, 8'h80, 8'd8,   8'h80, 1'b0, 1'b0, 1'b0, 0};
    tbl[8]  = '{3'b000, 8'h01, 8'd9,   8'h00, 1'b1, 1'b1, 1'b0, 8};
    tbl[9]  = '{3'b100, 8'h00, 8'd3,   8'h00, 1'b0, 1'b1, 1'b0, 3};
    tbl[10] = '{3'b101, 8'h00, 8'd0,   8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[11] = '{3'b010, 8'h03, 8'd1,   8'h01, 1'b1, 1'b0, 1'b0, 1};

    // Reset state
    RESET = 1'b1; START = 1'b0; OPCODE = 3'b000; DATA_IN = 8'h00; AMOUNT = 8'h00;
    #1;
    chk("rst_result",  {24'd0, RESULT}, 32'h00);
    chk("rst_carry",   {31'd0, CARRY},  32'd0);
    chk("rst_zero",    {31'd0, ZERO},   32'd1);
    chk("rst_busy",    {31'd0, BUSY},   32'd0);
    chk("rst_done",    {31'd0, DONE},   32'd0);
    chk("rst_illegal", {31'd0, ILLEGAL}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven operations
    held = 8'h00;
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("v%0d", i);
      start_op(tbl[i].op, tbl[i].din, tbl[i].amt);
      wait_done(nm, held, lat, bn, un);
      chk({nm, "_latency"}, lat, tbl[i].n);
      chk({nm, "_busy_cycles"}, bn, tbl[i].n);
      chk({nm, "_hold_during_shift"}, un, 32'd0);
      chk({nm, "_result"},  {24'd0, RESULT}, {24'd0, tbl[i].res});
      chk({nm, "_carry"},   {31'd0, CARRY},  {31'd0, tbl[i].car});
      chk({nm, "_zero"},    {31'd0, ZERO},   {31'd0, tbl[i].zer});
      chk({nm, "_illegal"}, {31'd0, ILLEGAL}, {31'd0, tbl[i].ill});
      @(posedge CLK);
      #1;
      chk({nm, "_done_one_cycle"}, {30'd0, DONE, BUSY}, 32'd0);
      held = tbl[i].res;
    end

    // START during SHIFT is ignored: LSL 0x81 by 3 -> 0x08, carry 0
    start_op(3'b000, 8'h81, 8'd3);
    chk("mid_busy", {31'd0, BUSY}, 32'd1);
    chk("mid_hold0", {24'd0, RESULT}, {24'd0, held});
    start_op(3'b100, 8'hFF, 8'd1);
    wait_done("mid", held, lat, bn, un);
    chk("mid_latency", lat, 32'd2);
    chk("mid_hold", un, 32'd0);
    chk("mid_result", {24'd0, RESULT}, 32'h08);
    chk("mid_carry", {31'd0, CARRY}, 32'd0);
    @(posedge CLK);
    #1;
    chk("mid_no_second_op", {30'd0, DONE, BUSY}, 32'd0);

    // Back-to-back: START sampled in FINISH
    start_op(3'b100, 8'h01, 8'd1);
    wait_done("b2b_a", 8'h08, lat, bn, un);
    chk("b2b_a_result", {24'd0, RESULT}, 32'h80);
    start_op(3'b001, 8'h80, 8'd2);
    chk("b2b_busy", {30'd0, BUSY, DONE}, 32'd2);
    wait_done("b2b_b", 8'h80, lat, bn, un);
    chk("b2b_latency", lat, 32'd2);
    chk("b2b_result", {24'd0, RESULT}, 32'h20);
    chk("b2b_carry", {31'd0, CARRY}, 32'd0);
    @(posedge CLK);
    #1;

    // Reset between edges during SHIFT
    start_op(3'b001, 8'hFF, 8'd8);
    @(posedge CLK);
    #3;
    chk("rstmid_busy_before", {31'd0, BUSY}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("rstmid_result",  {24'd0, RESULT}, 32'h00);
    chk("rstmid_flags", {27'd0, CARRY, ZERO, BUSY, DONE, ILLEGAL}, 32'b01000);
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (DONE) dn++;
    end
    chk("rstmid_no_done", dn, 32'd0);
    start_op(3'b011, 8'h81, 8'd1);
    wait_done("post_rst", 8'h00, lat, bn, un);
    chk("post_rst_latency", lat, 32'd1);
    chk("post_rst_result", {24'd0, RESULT}, 32'h03);
    chk("post_rst_carry", {31'd0, CARRY}, 32'd1);
    chk("post_rst_zero", {31'd0, ZERO}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width; only 8 is supported.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port START  input  1  request pulse, sampled on CLK rising edge.
REQ-005 The block SHALL have port OPCODE  input  3  shift operation: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 illegal.
REQ-006 The block SHALL have port DATA_IN  input  8  operand to shift.
REQ-007 The block SHALL have port AMOUNT  input  8  unsigned shift count.
REQ-008 The block SHALL have port RESULT  output  8  registered shifted value.
REQ-009 The block SHALL have port CARRY  output  1  last bit shifted or rotated out; 0 when effective count is 0.
REQ-010 The block SHALL have port ZERO  output  1  high when RESULT is 0x00.
REQ-011 The block SHALL have port BUSY  output  1  high while shifting.
REQ-012 The block SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port ILLEGAL  output  1  high with DONE when the latched opcode is 101-111.

Function
REQ-014 The block SHALL implement FSM states IDLE, SHIFT and FINISH.
REQ-015 The block SHALL accept START only in IDLE or FINISH (BUSY=0); START during SHIFT SHALL be ignored without corrupting the operation in flight.
REQ-016 On acceptance, the block SHALL latch DATA_IN into a working register, latch OPCODE, and compute effective count N: LSL/LSR/ASR N=min(AMOUNT,8); ROL/ROR N=AMOUNT mod 8; illegal N=0.
REQ-017 If N=0, the block SHALL go to FINISH on the accepting edge k.
REQ-018 If N>0, the block SHALL go to SHIFT on edge k with the count set to N.
REQ-019 In SHIFT, each edge SHALL perform exactly one 1-bit step, capture the bit moved out, and decrement the count.
REQ-020 The edge that performs the step with count=1 SHALL move the FSM to FINISH, so DONE is high in the cycle after edge k+N (N=0: after edge k).
REQ-021 LSL steps SHALL shift toward bit 7 with 0 into bit 0 and bit 7 out.
REQ-022 LSR steps SHALL shift toward bit 0 with 0 into bit 7 and bit 0 out.
REQ-023 ASR steps SHALL shift toward bit 0 with bit 7 replicated and bit 0 out.
REQ-024 ROL steps SHALL move bit 7 into bit 0, with CARRY equal to that bit.
REQ-025 ROR steps SHALL move bit 0 into bit 7, with CARRY equal to that bit.
REQ-026 On entering FINISH, the block SHALL load RESULT, CARRY, ZERO and ILLEGAL; illegal ops SHALL give RESULT=DATA_IN and CARRY=0.
REQ-027 RESULT, CARRY, ZERO and ILLEGAL SHALL hold until the next FINISH entry and SHALL be unchanged during SHIFT.
REQ-028 DONE SHALL be high for exactly the FINISH cycle; FINISH SHALL return to IDLE unless START is sampled, which starts a back-to-back operation.
REQ-029 BUSY SHALL equal (state==SHIFT).

Reset
REQ-030 RESET high SHALL force state IDLE, count 0, and RESULT=0x00, CARRY=0, ZERO=1, BUSY=0, DONE=0, ILLEGAL=0 immediately, regardless of CLK.
REQ-031 Reset during SHIFT SHALL abort the operation with no DONE pulse; after RESET is released, the first START SHALL behave as from power-up.

Verification
REQ-032 The bench SHALL check: LSL, DATA_IN=0x81, AMOUNT=1 -> DONE after edge k+1, RESULT=0x02, CARRY=1, ZERO=0.
REQ-033 The bench SHALL check: ASR, 0x90, AMOUNT=3 -> BUSY for 3 cycles, RESULT=0xF2, CARRY=0.
REQ-034 The bench SHALL check: ROL, 0xA5, AMOUNT=12 -> N=4, RESULT=0x5A, CARRY=0; ROR, 0x01, AMOUNT=1 -> RESULT=0x80, CARRY=1.
REQ-035 The bench SHALL check: LSR, 0xFF, AMOUNT=200 -> 8 shift cycles, RESULT=0x00, CARRY=1, ZERO=1; AMOUNT=0 -> DONE after edge k, RESULT=DATA_IN, CARRY=0.
REQ-036 The bench SHALL check: START pulsed mid-SHIFT with different operands -> ignored, first result intact; OPCODE=111 -> ILLEGAL=1, RESULT=DATA_IN.
REQ-037 The bench SHALL check: RESET asserted mid-SHIFT between clock edges -> outputs at reset values at once, no DONE; the next op completes correctly.
